// File: rtl/elastic_loader_pkg.sv
// elastic_loader_pkg
//   Shared definitions for the ElasticPE config loader and its bench:
//   default width constants, the loader state enum, the config record
//   struct and the per-record checksum term.
package elastic_loader_pkg;

    localparam int DEF_PE_NUM                  = 16;
    localparam int DEF_CONTEXT_SIZE            = 8;
    localparam int DEF_CONTEXT_SIZE_BIT_LENGTH = 3;
    localparam int DEF_INPUT_NUM_BIT_LENGTH    = 3;
    localparam int DEF_NEIGHBOR_PE_NUM         = 4;
    localparam int DEF_OPERATION_BIT_LENGTH    = 4;
    localparam int DEF_DATA_WIDTH              = 32;
    localparam int DEF_CYCLE_WIDTH             = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DONE
    } ldr_state_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]           cst;
        logic [DEF_OPERATION_BIT_LENGTH-1:0] op;
        logic [DEF_NEIGHBOR_PE_NUM-1:0]      out_mask;
        logic [DEF_INPUT_NUM_BIT_LENGTH-1:0] in2;
        logic [DEF_INPUT_NUM_BIT_LENGTH-1:0] in1;
    } cfg_rec_t;

    // Constant XOR the zero-extended packed control fields.
    function automatic logic [DEF_DATA_WIDTH-1:0] rec_term(input cfg_rec_t r);
        return r.cst ^ DEF_DATA_WIDTH'({r.op, r.out_mask, r.in2, r.in1});
    endfunction

endpackage

// File: rtl/elastic_exec_timer.sv
// elastic_exec_timer
//   Loadable down-counter timing the execution window.
//   load/load_value : preset the count (load wins over enable)
//   enable          : count down one per cycle
//   tc              : terminal count, high while enabled with count at 0
module elastic_exec_timer #(
    parameter int CYCLE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [CYCLE_WIDTH-1:0] load_value,
    input  logic                   enable,
    output logic                   tc
);
    logic [CYCLE_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (enable && count != '0)
            count <= count - CYCLE_WIDTH'(1);
    end

    assign tc = enable && (count == '0);

endmodule

// File: rtl/elastic_config_loader.sv
// elastic_config_loader
//   Streams configuration records into an ElasticPE array's context memories,
//   then fires one start_exec pulse and times the execution window.
//   Inputs : load_req/abort control, context_max_id, exec_cycles,
//            expected_checksum, cfg_valid + cfg_* record fields
//   Outputs: cfg_ready, registered config_* fields, one-hot
//            write_config_data, config_index, mapping_context_max_id,
//            start_exec, busy, done, checksum_error
//   Optional: ELASTIC_CONFIG_LOADER_CHECKSUM_EN adds a record checksum that
//            must match expected_checksum before execution is started.
module elastic_config_loader
    import elastic_loader_pkg::*;
#(
    parameter int PE_NUM                  = DEF_PE_NUM,
    parameter int CONTEXT_SIZE            = DEF_CONTEXT_SIZE,
    parameter int CONTEXT_SIZE_BIT_LENGTH = DEF_CONTEXT_SIZE_BIT_LENGTH,
    parameter int INPUT_NUM_BIT_LENGTH    = DEF_INPUT_NUM_BIT_LENGTH,
    parameter int NEIGHBOR_PE_NUM         = DEF_NEIGHBOR_PE_NUM,
    parameter int OPERATION_BIT_LENGTH    = DEF_OPERATION_BIT_LENGTH,
    parameter int DATA_WIDTH              = DEF_DATA_WIDTH,
    parameter int CYCLE_WIDTH             = DEF_CYCLE_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               load_req,
    input  logic                               abort,
    input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] context_max_id,
    input  logic [CYCLE_WIDTH-1:0]             exec_cycles,
    input  logic [DATA_WIDTH-1:0]              expected_checksum,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_in_index_1,
    input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_in_index_2,
    input  logic [NEIGHBOR_PE_NUM-1:0]         cfg_out_mask,
    input  logic [OPERATION_BIT_LENGTH-1:0]    cfg_op,
    input  logic [DATA_WIDTH-1:0]              cfg_const,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
    output logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index,
    output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
    output logic [DATA_WIDTH-1:0]              config_const_data,
    output logic [PE_NUM-1:0]                  write_config_data,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
    output logic                               start_exec,
    output logic                               busy,
    output logic                               done,
    output logic                               checksum_error
);
    localparam int CB   = CONTEXT_SIZE_BIT_LENGTH;
    localparam int PE_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
    localparam logic [PE_W-1:0] LAST_PE = PE_W'(PE_NUM - 1);
    localparam logic [CB-1:0]   MAX_CTX = CB'(CONTEXT_SIZE - 1);

    ldr_state_t           state, state_nxt;
    logic [PE_W-1:0]      pe_cnt;
    logic [CB-1:0]        ctx_cnt;
    logic [CB-1:0]        max_in;
    logic [CYCLE_WIDTH-1:0] exec_len;
    logic                 hs, last_rec, accept, chk_ok;
    logic                 tmr_load, tmr_tc;

    assign cfg_ready = (state == ST_LOAD);
    assign busy      = (state != ST_IDLE);
    assign hs        = cfg_valid && cfg_ready;
    assign last_rec  = hs && (pe_cnt == LAST_PE) && (ctx_cnt == mapping_context_max_id);
    assign accept    = (state == ST_IDLE) && load_req && !abort;
    assign max_in    = (context_max_id > MAX_CTX) ? MAX_CTX : context_max_id;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        case (state)
            ST_IDLE:  if (load_req) state_nxt = ST_LOAD;
            ST_LOAD:  if (last_rec) state_nxt = chk_ok ? ST_START : ST_DONE;
            ST_START: begin
                tmr_load  = 1'b1;
                state_nxt = (exec_len == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN:   if (tmr_tc) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (abort) state_nxt = ST_IDLE;
    end

    // RUN lasts exec_len cycles: preset to exec_len-1, terminal at 0.
    elastic_exec_timer #(.CYCLE_WIDTH(CYCLE_WIDTH)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_value (exec_len - CYCLE_WIDTH'(1)),
        .enable     (state == ST_RUN),
        .tc         (tmr_tc)
    );

    // start_exec/done are registered off the state so that the final strobe
    // lands a full cycle before start_exec.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pe_cnt                  <= '0;
            ctx_cnt                 <= '0;
            exec_len                <= '0;
            mapping_context_max_id  <= '0;
            write_config_data       <= '0;
            config_index            <= '0;
            config_input_PE_index_1 <= '0;
            config_input_PE_index_2 <= '0;
            config_output_PE_index  <= '0;
            config_op               <= '0;
            config_const_data       <= '0;
            start_exec              <= 1'b0;
            done                    <= 1'b0;
        end else begin
            write_config_data <= '0;
            start_exec        <= (state == ST_START) && !abort;
            done              <= (state == ST_DONE) && !abort;
            if (accept) begin
                mapping_context_max_id <= max_in;
                exec_len               <= exec_cycles;
                pe_cnt                 <= '0;
                ctx_cnt                <= '0;
            end else if (hs && !abort) begin
                write_config_data       <= PE_NUM'(1) << pe_cnt;
                config_index            <= ctx_cnt;
                config_input_PE_index_1 <= cfg_in_index_1;
                config_input_PE_index_2 <= cfg_in_index_2;
                config_output_PE_index  <= cfg_out_mask;
                config_op               <= cfg_op;
                config_const_data       <= cfg_const;
                if (pe_cnt == LAST_PE) begin
                    pe_cnt  <= '0;
                    ctx_cnt <= ctx_cnt + CB'(1);
                end else begin
                    pe_cnt <= pe_cnt + PE_W'(1);
                end
            end
        end
    end

`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] chk_acc, chk_nxt, rec_term_v;
    logic                  chk_err;

    assign rec_term_v = cfg_const ^ DATA_WIDTH'({cfg_op, cfg_out_mask, cfg_in_index_2, cfg_in_index_1});
    assign chk_nxt    = chk_acc + rec_term_v;
    // Compared including the record being accepted this cycle.
    assign chk_ok     = (chk_nxt == expected_checksum);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chk_acc <= '0;
            chk_err <= 1'b0;
        end else if (accept) begin
            chk_acc <= '0;
            chk_err <= 1'b0;
        end else if (hs && !abort) begin
            chk_acc <= chk_nxt;
            if (last_rec && !chk_ok) chk_err <= 1'b1;
        end
    end

    assign checksum_error = chk_err;
`else
    logic unused_checksum;
    assign unused_checksum = ^expected_checksum;
    assign chk_ok          = 1'b1;
    assign checksum_error  = 1'b0;
`endif

endmodule

// File: tb/tb_elastic_config_loader.sv
// tb_elastic_config_loader
//   Randomized bench with a transaction-level reference model (record count,
//   absolute cycle numbers for start/done/busy) and a per-cycle compare
//   process, plus literal checks of strobe order and window timing.
//   Honours ELASTIC_CONFIG_LOADER_CHECKSUM_EN like the design.
module tb_elastic_config_loader;
    import elastic_loader_pkg::*;

    localparam int NPE = 4;
    localparam longint BIG = 64'd1 << 40;

    logic        clk = 1'b0;
    logic        reset_n, load_req, abort, cfg_valid, cfg_ready;
    logic [2:0]  context_max_id, cfg_in_index_1, cfg_in_index_2;
    logic [31:0] exec_cycles, expected_checksum, cfg_const;
    logic [3:0]  cfg_out_mask, cfg_op;
    logic [2:0]  config_input_PE_index_1, config_input_PE_index_2;
    logic [3:0]  config_output_PE_index, config_op;
    logic [31:0] config_const_data;
    logic [NPE-1:0] write_config_data;
    logic [2:0]  config_index, mapping_context_max_id;
    logic        start_exec, busy, done, checksum_error;

    elastic_config_loader #(.PE_NUM(NPE)) dut (
        .clk(clk), .reset_n(reset_n), .load_req(load_req), .abort(abort),
        .context_max_id(context_max_id), .exec_cycles(exec_cycles),
        .expected_checksum(expected_checksum), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_in_index_1(cfg_in_index_1), .cfg_in_index_2(cfg_in_index_2),
        .cfg_out_mask(cfg_out_mask), .cfg_op(cfg_op), .cfg_const(cfg_const),
        .config_input_PE_index_1(config_input_PE_index_1),
        .config_input_PE_index_2(config_input_PE_index_2),
        .config_output_PE_index(config_output_PE_index), .config_op(config_op),
        .config_const_data(config_const_data), .write_config_data(write_config_data),
        .config_index(config_index), .mapping_context_max_id(mapping_context_max_id),
        .start_exec(start_exec), .busy(busy), .done(done), .checksum_error(checksum_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (time %0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint   cyc, bs, be, start_c, done_c, m_E;
    int       m_n, m_total;
    bit       m_ready, m_err;
    logic [2:0]  m_max, e_idx;
    logic [3:0]  e_strobe;
    logic [31:0] m_chk;
    cfg_rec_t    e_rec;

    function automatic bit m_busy_at(input longint c);
        return (bs <= c) && (c <= be);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0; bs = 1; be = 0; start_c = -1; done_c = -1; m_E = 0;
            m_n = 0; m_total = 0; m_ready = 0; m_err = 0; m_max = 0;
            e_idx = 0; e_strobe = 0; m_chk = 0; e_rec = '0;
        end else begin
            longint c;
            bit     mism;
            c = cyc;
            e_strobe = 0;
            if (abort) begin
                if (m_busy_at(c)) begin
                    be = c; m_ready = 0;
                    if (start_c > c) start_c = -1;
                    if (done_c > c)  done_c = -1;
                end
            end else if (load_req && !m_busy_at(c)) begin
                m_max   = (context_max_id > 3'(DEF_CONTEXT_SIZE - 1)) ? 3'(DEF_CONTEXT_SIZE - 1) : context_max_id;
                m_E     = longint'(exec_cycles);
                m_total = (int'(m_max) + 1) * NPE;
                m_n = 0; m_chk = 0; m_err = 0; m_ready = 1;
                bs = c + 1; be = BIG; start_c = -1; done_c = -1;
            end else if (m_ready && cfg_valid) begin
                e_rec    = '{cst: cfg_const, op: cfg_op, out_mask: cfg_out_mask,
                             in2: cfg_in_index_2, in1: cfg_in_index_1};
                e_strobe = 4'(1 << (m_n % NPE));
                e_idx    = 3'(m_n / NPE);
                m_chk    = m_chk + rec_term(e_rec);
                m_n++;
                if (m_n == m_total) begin
                    m_ready = 0;
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
                    mism = (m_chk != expected_checksum);
`else
                    mism = 0;
`endif
                    if (mism) begin
                        m_err = 1; done_c = c + 2; be = c + 1;
                    end else begin
                        start_c = c + 2;
                        done_c  = (m_E == 0) ? c + 3 : c + 3 + m_E;
                        be      = done_c - 1;
                    end
                end
            end
            cyc = c + 1;
        end
    end

    // ---------------- per-cycle compare + event log ----------------
    logic [3:0] log_strb[$];
    logic [2:0] log_idx[$];
    longint last_strb_c = 0, start_seen_c = 0, done_seen_c = 0;
    int     start_cnt = 0, done_cnt = 0;

    always @(negedge clk) begin
        chk("busy", busy, m_busy_at(cyc));
        chk("cfg_ready", cfg_ready, m_ready);
        chk("strobe", write_config_data, e_strobe);
        chk("start_exec", start_exec, cyc == start_c);
        chk("done", done, cyc == done_c);
        chk("max_id", mapping_context_max_id, m_max);
        chk("checksum_error", checksum_error, m_err);
        if (e_strobe != 0) begin
            chk("config_index", config_index, e_idx);
            chk("f_const", config_const_data, e_rec.cst);
            chk("f_op", config_op, e_rec.op);
            chk("f_mask", config_output_PE_index, e_rec.out_mask);
            chk("f_in1", config_input_PE_index_1, e_rec.in1);
            chk("f_in2", config_input_PE_index_2, e_rec.in2);
        end
        if (write_config_data != 0) begin
            log_strb.push_back(write_config_data);
            log_idx.push_back(config_index);
            last_strb_c = cyc;
        end
        if (start_exec) begin start_cnt++; start_seen_c = cyc; end
        if (done)       begin done_cnt++;  done_seen_c  = cyc; end
    end

    // ---------------- stimulus ----------------
    cfg_rec_t recs[32];

    task automatic apply_rec(input int i);
        {cfg_const, cfg_op, cfg_out_mask, cfg_in_index_2, cfg_in_index_1} = recs[i % 32];
    endtask

    task automatic run_scn(input int cmid, input int E, input int vmode, input int abort_at,
                           input int delta, input bit lr_in_run, input bit abort_run);
        logic [31:0] sum;
        int nrec, k;
        bit aborted;
        sum = 0;
        nrec = (cmid + 1) * NPE;
        for (int i = 0; i < 32; i++) begin
            recs[i] = cfg_rec_t'({$urandom, $urandom});
            if (i < nrec) sum = sum + rec_term(recs[i]);
        end
        expected_checksum = sum + 32'(delta);
        @(negedge clk);
        load_req = 1; context_max_id = 3'(cmid); exec_cycles = 32'(E);
        @(negedge clk);
        load_req = 0; context_max_id = 3'($urandom); exec_cycles = $urandom_range(0, 9);
        k = 0; aborted = 0;
        while (m_ready && k < 2000) begin
            apply_rec(m_n);
            case (vmode)
                0:       cfg_valid = 1;
                1:       cfg_valid = (k % 2 == 0);
                default: cfg_valid = 1'($urandom);
            endcase
            if (abort_at >= 0 && m_n == abort_at) begin abort = 1; aborted = 1; end
            @(negedge clk);
            abort = 0; k++;
            if (aborted) break;
        end
        cfg_valid = 0;
        while (m_busy_at(cyc) && k < 2000) begin
            if (lr_in_run && cyc == start_c + 2) begin
                load_req = 1; exec_cycles = 2; context_max_id = 0;
            end
            if (abort_run && cyc == start_c + 2) abort = 1;
            @(negedge clk);
            load_req = 0; abort = 0; k++;
        end
        if (k >= 2000) chk("timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n0, s0, d0;
        reset_n = 0; load_req = 0; abort = 0; cfg_valid = 0; context_max_id = 0;
        exec_cycles = 0; expected_checksum = 0;
        cfg_in_index_1 = 0; cfg_in_index_2 = 0; cfg_out_mask = 0; cfg_op = 0; cfg_const = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_ready", cfg_ready, 0);
        chk("reset_max", mapping_context_max_id, 0);
        reset_n = 1;

        // Basic load: max=1, 5 exec cycles, valid held high.
        n0 = log_strb.size();
        run_scn(1, 5, 0, -1, 0, 0, 0);
        chk("A_count", log_strb.size() - n0, 8);
        for (int i = 0; i < 8; i++) begin
            chk("A_strobe", log_strb[n0 + i], 1 << (i % 4));
            chk("A_index", log_idx[n0 + i], i / 4);
        end
        chk("A_start_lat", start_seen_c - last_strb_c, 1);
        chk("A_done_lat", done_seen_c - start_seen_c, 6);

        // Toggling cfg_valid: same order, one strobe per handshake.
        n0 = log_strb.size();
        run_scn(1, 5, 1, -1, 0, 0, 0);
        chk("B_count", log_strb.size() - n0, 8);
        for (int i = 0; i < 8; i++) chk("B_strobe", log_strb[n0 + i], 1 << (i % 4));

        // Largest context id.
        n0 = log_strb.size();
        run_scn(15, 3, 2, -1, 0, 0, 0);
        chk("C_max", mapping_context_max_id, 7);
        chk("C_count", log_strb.size() - n0, 32);

        // Abort after the third handshake, then a clean restart.
        s0 = start_cnt; d0 = done_cnt;
        run_scn(1, 5, 0, 3, 0, 0, 0);
        chk("D_nostart", start_cnt - s0, 0);
        chk("D_nodone", done_cnt - d0, 0);
        n0 = log_strb.size();
        run_scn(0, 2, 0, -1, 0, 0, 0);
        chk("D_restart_strobe", log_strb[n0], 1);
        chk("D_restart_index", log_idx[n0], 0);

        // Zero-length window, then load_req during RUN.
        run_scn(0, 0, 0, -1, 0, 0, 0);
        chk("E_zero_lat", done_seen_c - start_seen_c, 1);
        run_scn(0, 7, 0, -1, 0, 1, 0);
        chk("E_ignored_lr", done_seen_c - start_seen_c, 8);

        // Checksum off by one, then correct.
        s0 = start_cnt; d0 = done_cnt;
        run_scn(1, 2, 0, -1, 1, 0, 0);
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
        chk("F_err", checksum_error, 1);
        chk("F_nostart", start_cnt - s0, 0);
        chk("F_done", done_cnt - d0, 1);
`else
        chk("F_err", checksum_error, 0);
        chk("F_start", start_cnt - s0, 1);
`endif
        s0 = start_cnt;
        run_scn(1, 2, 0, -1, 0, 0, 0);
        chk("F_ok_err", checksum_error, 0);
        chk("F_ok_start", start_cnt - s0, 1);

        // Randomized loads, aborts and stray load_reqs.
        for (int r = 0; r < 12; r++)
            run_scn($urandom_range(0, 7), $urandom_range(0, 20), $urandom_range(0, 2),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1,
                    ($urandom_range(0, 3) == 0) ? 1 : 0,
                    1'($urandom), ($urandom_range(0, 4) == 0));

        // Reset in the middle of a load.
        @(negedge clk);
        load_req = 1; context_max_id = 3; exec_cycles = 4;
        @(negedge clk);
        load_req = 0; cfg_valid = 1;
        repeat (5) @(negedge clk);
        #2 reset_n = 0;
        repeat (2) @(negedge clk);
        chk("R_busy", busy, 0);
        chk("R_strobe", write_config_data, 0);
        chk("R_max", mapping_context_max_id, 0);
        cfg_valid = 0;
        #2 reset_n = 1;
        run_scn(1, 3, 0, -1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
